// File: rtl/pq_req_arbiter_pkg.sv
// Shared types for the priority-queue request arbiter: FSM states and settle-counter width.
package pq_pkg;
    localparam int SETTLE_CNT_W = 3;

    typedef enum logic [1:0] {
        INIT   = 2'd0,
        IDLE   = 2'd1,
        SETTLE = 2'd2
    } pq_state_e;
endpackage

// File: rtl/pq_req_arbiter_rr_pick.sv
// Round-robin picker: one-hot grant to the first set request at or above ptr, wrapping.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] ptr,
    output logic [N_REQ-1:0] gnt
);
    logic             found_s;
    logic [PTR_W-1:0] idx_s;

    // Scan requesters starting at ptr; the first hit wins.
    always_comb begin
        gnt     = '0;
        found_s = 1'b0;
        idx_s   = '0;
        for (int k = 0; k < N_REQ; k++) begin
            idx_s = PTR_W'((int'(ptr) + k) % N_REQ);
            if (!found_s && req[idx_s]) begin
                gnt[idx_s] = 1'b1;
                found_s    = 1'b1;
            end else begin
                found_s = found_s;
            end
        end
    end
endmodule

// File: rtl/pq_req_arbiter.sv
// Arbitrates N_REQ push requesters and one pop consumer onto a single priority queue,
// inserting settle cycles after each queue operation.
module pq_req_arbiter
    import pq_pkg::*;
#(
    parameter int N_REQ         = 4,
    parameter int DATA_WIDTH    = 16,
    parameter int ENQ_ENA       = 1,
    parameter int SETTLE_CYCLES = 1
) (
    input  logic                             i_CLK,
    input  logic                             i_RSTn,
    input  logic [N_REQ-1:0]                 i_push_valid,
    input  logic [N_REQ-1:0][DATA_WIDTH-1:0] i_push_data,
    output logic [N_REQ-1:0]                 o_push_ready,
    output logic                             o_pop_valid,
    output logic [DATA_WIDTH-1:0]            o_pop_data,
    input  logic                             i_pop_ready,
    output logic                             o_pq_wrt,
    output logic                             o_pq_read,
    output logic [DATA_WIDTH-1:0]            o_pq_data,
    input  logic                             i_pq_full,
    input  logic                             i_pq_empty,
    input  logic [DATA_WIDTH-1:0]            i_pq_data,
    output logic                             o_zero_drop
);
    localparam int RR_W = $clog2(N_REQ);

    pq_state_e               state_r, state_nxt_s;
    logic [SETTLE_CNT_W-1:0] cnt_r, cnt_nxt_s;
    logic [RR_W-1:0]         rr_r, rr_nxt_s;

    logic [N_REQ-1:0]      real_req_s, zero_req_s, pick_req_s, pick_gnt_s;
    logic                  idle_s, pop_fire_s, can_push_s, push_fire_s;
    logic [RR_W-1:0]       gnt_idx_s;
    logic [DATA_WIDTH-1:0] gnt_key_s;

    // Split requests into real keys and zero keys (zero keys are dropped, not queued).
    always_comb begin
        real_req_s = '0;
        zero_req_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            real_req_s[i] = i_push_valid[i] && (i_push_data[i] != '0);
            zero_req_s[i] = i_push_valid[i] && (i_push_data[i] == '0);
        end
    end

    // Decide whether a real push may go this cycle; a pop always makes room as a replace.
    always_comb begin
        idle_s     = (state_r == IDLE);
        pop_fire_s = idle_s && !i_pq_empty && i_pop_ready;
        if (pop_fire_s) begin
            can_push_s = 1'b1;
        end else if (ENQ_ENA != 32'sd0) begin
            can_push_s = !i_pq_full;
        end else begin
            can_push_s = i_pq_empty;
        end
        push_fire_s = idle_s && (|real_req_s) && can_push_s;
        if (push_fire_s) begin
            pick_req_s = real_req_s;
        end else if (idle_s) begin
            pick_req_s = zero_req_s;
        end else begin
            pick_req_s = '0;
        end
    end

    rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (RR_W)
    ) u_rr_pick (
        .req (pick_req_s),
        .ptr (rr_r),
        .gnt (pick_gnt_s)
    );

    // Decode the one-hot grant into an index and the granted key.
    always_comb begin
        gnt_idx_s = '0;
        gnt_key_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (pick_gnt_s[i]) begin
                gnt_idx_s = RR_W'(i);
                gnt_key_s = i_push_data[i];
            end else begin
                gnt_idx_s = gnt_idx_s;
            end
        end
    end

    // Handshake and strobe outputs; with ENQ_ENA=0 a lone push goes out as a replace.
    always_comb begin
        o_push_ready = pick_gnt_s;
        o_pop_valid  = idle_s && !i_pq_empty;
        o_pop_data   = i_pq_data;
        o_pq_wrt     = push_fire_s;
        o_pq_read    = pop_fire_s || (push_fire_s && (ENQ_ENA == 32'sd0));
        o_pq_data    = push_fire_s ? gnt_key_s : '0;
        o_zero_drop  = !push_fire_s && (|pick_gnt_s);
    end

    // Next-state, settle counter and round-robin pointer.
    always_comb begin
        state_nxt_s = state_r;
        cnt_nxt_s   = cnt_r;
        rr_nxt_s    = rr_r;
        if (|pick_gnt_s) begin
            if (gnt_idx_s == RR_W'(N_REQ - 1)) begin
                rr_nxt_s = '0;
            end else begin
                rr_nxt_s = gnt_idx_s + RR_W'(1);
            end
        end else begin
            rr_nxt_s = rr_r;
        end
        case (state_r)
            INIT: begin
                state_nxt_s = IDLE;
                cnt_nxt_s   = '0;
            end
            IDLE: begin
                if ((o_pq_wrt || o_pq_read) && (SETTLE_CYCLES != 32'sd0)) begin
                    state_nxt_s = SETTLE;
                    cnt_nxt_s   = SETTLE_CNT_W'(SETTLE_CYCLES);
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            SETTLE: begin
                if (cnt_r <= SETTLE_CNT_W'(1)) begin
                    state_nxt_s = IDLE;
                    cnt_nxt_s   = '0;
                end else begin
                    cnt_nxt_s = cnt_r - SETTLE_CNT_W'(1);
                end
            end
            default: begin
                state_nxt_s = INIT;
                cnt_nxt_s   = '0;
            end
        endcase
    end

    // State registers with asynchronous active-low reset.
    always_ff @(posedge i_CLK or negedge i_RSTn) begin
        if (!i_RSTn) begin
            state_r <= INIT;
            cnt_r   <= '0;
            rr_r    <= '0;
        end else begin
            state_r <= state_nxt_s;
            cnt_r   <= cnt_nxt_s;
            rr_r    <= rr_nxt_s;
        end
    end
endmodule

// File: tb/tb_pq_req_arbiter.sv
// Bench for pq_req_arbiter: two configurations driven in parallel, checked against a
// cycle-level behavioural model plus directed literal expectations.
module tb_pq_req_arbiter;
    localparam int N  = 4;
    localparam int DW = 16;
    localparam int NI = 2;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic [N-1:0]           push_valid = '0;
    logic [N-1:0][DW-1:0]   push_data = '0;
    logic                   pop_ready = 1'b0;
    logic                   pq_full = 1'b0;
    logic                   pq_empty = 1'b1;
    logic [DW-1:0]          pq_data = 16'h1234;

    logic [N-1:0]  rdy_o [NI];
    logic          pv_o  [NI];
    logic          wr_o  [NI];
    logic          rd_o  [NI];
    logic          zd_o  [NI];
    logic [DW-1:0] pd_o  [NI];
    logic [DW-1:0] qd_o  [NI];

    int n_checks = 0;
    int n_fail   = 0;

    bit m_init [NI] = '{1'b1, 1'b1};
    int m_dead [NI] = '{0, 0};
    int m_rr   [NI] = '{0, 0};
    int m_g    [NI] = '{-1, -1};
    bit m_op   [NI] = '{1'b0, 1'b0};

    always #5 clk = ~clk;

    pq_req_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ENQ_ENA(1), .SETTLE_CYCLES(1)) u_dut_a (
        .i_CLK(clk), .i_RSTn(rst_n), .i_push_valid(push_valid), .i_push_data(push_data),
        .o_push_ready(rdy_o[0]), .o_pop_valid(pv_o[0]), .o_pop_data(pd_o[0]), .i_pop_ready(pop_ready),
        .o_pq_wrt(wr_o[0]), .o_pq_read(rd_o[0]), .o_pq_data(qd_o[0]), .i_pq_full(pq_full),
        .i_pq_empty(pq_empty), .i_pq_data(pq_data), .o_zero_drop(zd_o[0]));

    pq_req_arbiter #(.N_REQ(N), .DATA_WIDTH(DW), .ENQ_ENA(0), .SETTLE_CYCLES(3)) u_dut_b (
        .i_CLK(clk), .i_RSTn(rst_n), .i_push_valid(push_valid), .i_push_data(push_data),
        .o_push_ready(rdy_o[1]), .o_pop_valid(pv_o[1]), .o_pop_data(pd_o[1]), .i_pop_ready(pop_ready),
        .o_pq_wrt(wr_o[1]), .o_pq_read(rd_o[1]), .o_pq_data(qd_o[1]), .i_pq_full(pq_full),
        .i_pq_empty(pq_empty), .i_pq_data(pq_data), .o_zero_drop(zd_o[1]));

    function automatic bit enq_of(input int k);
        return (k == 0);
    endfunction

    function automatic int set_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Expected outputs of instance k for the current inputs and model state.
    task automatic model_eval(input int k, output logic [N-1:0] rdy, output logic pv,
                              output logic wr, output logic rd, output logic [DW-1:0] d,
                              output logic zd, output int g);
        bit live, pop, can;
        int real_g, zero_g, idx;
        rdy = '0; pv = 1'b0; wr = 1'b0; rd = 1'b0; d = '0; zd = 1'b0; g = -1;
        live = (rst_n === 1'b1) && !m_init[k] && (m_dead[k] == 0);
        if (live) begin
            pv = !pq_empty;
            pop = pv && pop_ready;
            real_g = -1;
            zero_g = -1;
            for (int j = 0; j < N; j++) begin
                idx = (m_rr[k] + j) % N;
                if (push_valid[idx]) begin
                    if (push_data[idx] != '0) begin
                        if (real_g < 0) real_g = idx;
                    end else if (zero_g < 0) begin
                        zero_g = idx;
                    end
                end
            end
            if (pop) can = 1'b1;
            else if (enq_of(k)) can = !pq_full;
            else can = pq_empty;
            rd = pop;
            if (real_g >= 0 && can) begin
                g = real_g; wr = 1'b1; d = push_data[real_g];
                if (!enq_of(k)) rd = 1'b1;
            end else if (zero_g >= 0) begin
                g = zero_g; zd = 1'b1;
            end
            if (g >= 0) rdy[g] = 1'b1;
        end
    endtask

    // Every-cycle comparison of both instances against the model.
    initial begin : cmp
        logic [N-1:0]  e_rdy;
        logic          e_pv, e_wr, e_rd, e_zd;
        logic [DW-1:0] e_d;
        int            e_g;
        forever begin
            @(negedge clk);
            for (int k = 0; k < NI; k++) begin
                model_eval(k, e_rdy, e_pv, e_wr, e_rd, e_d, e_zd, e_g);
                m_g[k]  = e_g;
                m_op[k] = e_wr || e_rd;
                check($sformatf("dut%0d_push_ready", k), 32'(rdy_o[k]), 32'(e_rdy));
                check($sformatf("dut%0d_pop_valid", k), 32'(pv_o[k]), 32'(e_pv));
                check($sformatf("dut%0d_pop_data", k), 32'(pd_o[k]), 32'(pq_data));
                check($sformatf("dut%0d_pq_wrt", k), 32'(wr_o[k]), 32'(e_wr));
                check($sformatf("dut%0d_pq_read", k), 32'(rd_o[k]), 32'(e_rd));
                check($sformatf("dut%0d_pq_data", k), 32'(qd_o[k]), 32'(e_d));
                check($sformatf("dut%0d_zero_drop", k), 32'(zd_o[k]), 32'(e_zd));
            end
            @(posedge clk);
            for (int k = 0; k < NI; k++) begin
                if (rst_n !== 1'b1) begin
                    m_init[k] = 1'b1; m_rr[k] = 0; m_dead[k] = 0;
                end else if (m_init[k]) begin
                    m_init[k] = 1'b0;
                end else begin
                    if (m_g[k] >= 0) m_rr[k] = (m_g[k] + 1) % N;
                    if (m_op[k]) m_dead[k] = set_of(k);
                    else if (m_dead[k] > 0) m_dead[k]--;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic set_keys();
        push_data[0] = 16'd5; push_data[1] = 16'd9; push_data[2] = 16'd3; push_data[3] = 16'd7;
    endtask

    // Directed scenarios followed by randomized traffic.
    initial begin : stim
        int wrt_cnt, stall_cnt, first;
        logic [DW-1:0] keys [N];
        logic [N-1:0] exp_rdy;
        keys[0] = 16'd5; keys[1] = 16'd9; keys[2] = 16'd3; keys[3] = 16'd7;

        repeat (3) step();
        sample();
        check("rst_push_ready", 32'(rdy_o[0]), 32'd0);
        check("rst_pop_valid", 32'(pv_o[0]), 32'd0);
        step();
        rst_n = 1'b1; pq_empty = 1'b0;
        sample();
        check("init_pop_valid", 32'(pv_o[0]), 32'd0);
        check("init_pq_wrt", 32'(wr_o[0]), 32'd0);
        step();
        sample();
        check("idle_pop_valid_a", 32'(pv_o[0]), 32'd1);
        check("idle_pop_valid_b", 32'(pv_o[1]), 32'd1);

        step();
        push_valid = 4'hF; set_keys();
        wrt_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            sample();
            exp_rdy = (c % 2 == 0) ? (4'b0001 << (c / 2)) : 4'b0000;
            check($sformatf("rr_seq_c%0d", c), 32'(rdy_o[0]), 32'(exp_rdy));
            if (c % 2 == 0) check($sformatf("rr_key_c%0d", c), 32'(qd_o[0]), 32'(keys[c / 2]));
            if (wr_o[0]) wrt_cnt++;
            step();
            if (c % 2 == 0) push_valid[c / 2] = 1'b0;
        end
        check("rr_wrt_pulses", 32'(wrt_cnt), 32'd4);

        push_valid = 4'b0010; push_data = '0;
        sample();
        check("zero_push_ready", 32'(rdy_o[0]), 32'b0010);
        check("zero_drop_pulse", 32'(zd_o[0]), 32'd1);
        check("zero_no_strobes", 32'({wr_o[0], rd_o[0]}), 32'd0);
        step();
        push_valid = 4'hF; set_keys();
        sample();
        check("rr_after_zero", 32'(rdy_o[0]), 32'b0100);
        step();
        push_valid = '0;

        step();
        pq_full = 1'b1; pq_empty = 1'b0; pop_ready = 1'b1;
        push_valid = 4'b0100; push_data[2] = 16'h00AA;
        sample();
        check("full_replace_ready", 32'(rdy_o[0]), 32'b0100);
        check("full_replace_strobes", 32'({wr_o[0], rd_o[0]}), 32'b11);
        check("full_replace_data", 32'(qd_o[0]), 32'h00AA);
        step();
        push_valid = '0; pop_ready = 1'b0; pq_full = 1'b0;

        repeat (5) step();
        push_valid = 4'b0001; push_data[0] = 16'd4; pop_ready = 1'b0; pq_empty = 1'b0;
        stall_cnt = 0;
        for (int c = 0; c < 20; c++) begin
            sample();
            if (rdy_o[1] != '0 || wr_o[1] || rd_o[1]) stall_cnt++;
            step();
        end
        check("enq0_stall", 32'(stall_cnt), 32'd0);
        pop_ready = 1'b1;
        sample();
        check("enq0_replace_ready", 32'(rdy_o[1]), 32'b0001);
        check("enq0_replace_strobes", 32'({wr_o[1], rd_o[1]}), 32'b11);
        check("enq0_replace_data", 32'(qd_o[1]), 32'd4);

        step();
        rst_n = 1'b0;
        #1;
        check("rst_settle_ready", 32'(rdy_o[1]), 32'd0);
        check("rst_settle_outs", 32'({pv_o[1], wr_o[1], rd_o[1], zd_o[1]}), 32'd0);
        step();
        step();
        rst_n = 1'b1;
        first = -1;
        for (int c = 1; c <= 10; c++) begin
            sample();
            if ((wr_o[1] || rd_o[1]) && first < 0) first = c;
            step();
        end
        check("rst_first_strobe", 32'(first), 32'd2);

        for (int c = 0; c < 3000; c++) begin
            step();
            rst_n = ($urandom_range(0, 299) != 0);
            for (int i = 0; i < N; i++) begin
                push_valid[i] = ($urandom_range(0, 2) != 0);
                push_data[i]  = ($urandom_range(0, 3) == 0) ? '0 : DW'($urandom_range(1, 65535));
            end
            case ($urandom_range(0, 3))
                0: begin pq_empty = 1'b1; pq_full = 1'b0; end
                1: begin pq_empty = 1'b0; pq_full = 1'b1; end
                default: begin pq_empty = 1'b0; pq_full = 1'b0; end
            endcase
            pop_ready = $urandom_range(0, 1) != 0;
            pq_data   = DW'($urandom_range(0, 65535));
        end
        step();
        sample();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
